// File: rtl/global_typs_pkg.sv
// Shared constants, header record and FSM encoding for the UDP receive path.
package global_typs_pkg;

    localparam logic [7:0]  UDP_PROTO   = 8'd17;
    localparam logic [15:0] UDP_HDR_LEN = 16'd8;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] data_length;
    } udp_rx_hdr_t;

    typedef enum logic [1:0] {
        UDP_RX_IDLE,
        UDP_RX_HDR,
        UDP_RX_PAYLOAD,
        UDP_RX_DISCARD
    } udp_rx_state_t;

endpackage

// File: rtl/udp_rx_stats.sv
// Saturating receive statistics: accepted packets and dropped/errored packets.
module udp_rx_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        pkt_inc,
    input  logic        drop_inc,
    output logic [15:0] rx_pkt_cnt,
    output logic [15:0] rx_drop_cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_pkt_cnt  <= '0;
            rx_drop_cnt <= '0;
        end else begin
            if (pkt_inc && rx_pkt_cnt != 16'hFFFF)
                rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
            if (drop_inc && rx_drop_cnt != 16'hFFFF)
                rx_drop_cnt <= rx_drop_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/udp_rx.sv
// UDP receiver: parses the 8-byte UDP header from an IP payload stream and forwards the payload.
// Optional statistics counters are enabled with the UDP_RX_STATS_EN macro.
module udp_rx
    import global_typs_pkg::*;
#(
    parameter logic [15:0] PORT_FILTER = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ip_rx_start,
    input  logic [7:0]    ip_rx_protocol,
    input  logic [31:0]   ip_rx_src_ip,
    input  logic          ip_rx_data_valid,
    input  logic [7:0]    ip_rx_data,
    input  logic          ip_rx_data_last,
    output logic          udp_rx_start,
    output logic [31:0]   udp_rx_src_ip,
    output logic [15:0]   udp_rx_src_port,
    output logic [15:0]   udp_rx_dst_port,
    output logic [15:0]   udp_rx_data_length,
    output logic          udp_rx_data_valid,
    output logic [7:0]    udp_rx_data,
    output logic          udp_rx_data_last,
    output logic          udp_rx_err,
    output udp_rx_state_t fsm_state
`ifdef UDP_RX_STATS_EN
    ,
    output logic [15:0]   rx_pkt_cnt,
    output logic [15:0]   rx_drop_cnt
`endif
);

    // Streams are valid-only: a byte transfers on every cycle its valid is high; no ready exists.
    udp_rx_state_t state, state_nxt;
    logic [2:0]    hdr_cnt;
    logic [31:0]   src_ip_q;
    logic [15:0]   src_port_q, dst_port_q, len_q, pay_cnt;
    udp_rx_hdr_t   hdr_out;
    logic          is_udp, abort, hdr_byte, hdr_done, pay_byte, pay_end;
    logic          len_short, len_empty, port_ok;
    logic          start_nxt, err_nxt, dv_nxt, dlast_nxt;

    assign is_udp    = ip_rx_protocol == UDP_PROTO;
    assign abort     = ip_rx_start && state != UDP_RX_IDLE;
    assign hdr_byte  = !ip_rx_start && state == UDP_RX_HDR && ip_rx_data_valid;
    assign hdr_done  = hdr_byte && hdr_cnt == 3'd7;
    assign pay_byte  = !ip_rx_start && state == UDP_RX_PAYLOAD && ip_rx_data_valid;
    assign pay_end   = pay_cnt == 16'd1;
    assign len_short = len_q < UDP_HDR_LEN;
    assign len_empty = len_q == UDP_HDR_LEN;
    assign port_ok   = PORT_FILTER == 16'h0000 || dst_port_q == PORT_FILTER;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= UDP_RX_IDLE;
        else       state <= state_nxt;
    end

    // A new datagram always wins, whatever state the previous one left us in.
    always_comb begin
        state_nxt = state;
        if (ip_rx_start) begin
            state_nxt = is_udp ? UDP_RX_HDR : UDP_RX_DISCARD;
        end else if (ip_rx_data_valid) begin
            case (state)
                UDP_RX_HDR: begin
                    if (hdr_cnt == 3'd7) begin
                        if (ip_rx_data_last)        state_nxt = UDP_RX_IDLE;
                        else if (len_short || !port_ok || len_empty)
                                                    state_nxt = UDP_RX_DISCARD;
                        else                        state_nxt = UDP_RX_PAYLOAD;
                    end else if (ip_rx_data_last) begin
                        state_nxt = UDP_RX_IDLE;
                    end
                end
                UDP_RX_PAYLOAD: begin
                    if (pay_end)              state_nxt = ip_rx_data_last ? UDP_RX_IDLE : UDP_RX_DISCARD;
                    else if (ip_rx_data_last) state_nxt = UDP_RX_IDLE;
                end
                UDP_RX_DISCARD: begin
                    if (ip_rx_data_last) state_nxt = UDP_RX_IDLE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // A byte arriving with an abort in PAYLOAD closes the open stream with a last beat.
    always_comb begin
        start_nxt = hdr_done && !len_short && port_ok;
        err_nxt   = abort
                 || (hdr_byte && ip_rx_data_last && hdr_cnt != 3'd7)
                 || (hdr_done && len_short)
                 || (start_nxt && ip_rx_data_last && !len_empty)
                 || (pay_byte && ip_rx_data_last && !pay_end);
        dv_nxt    = pay_byte || (abort && state == UDP_RX_PAYLOAD && ip_rx_data_valid);
        dlast_nxt = (pay_byte && (pay_end || ip_rx_data_last))
                 || (abort && state == UDP_RX_PAYLOAD && ip_rx_data_valid);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_cnt           <= '0;
            src_ip_q          <= '0;
            src_port_q        <= '0;
            dst_port_q        <= '0;
            len_q             <= '0;
            pay_cnt           <= '0;
            hdr_out           <= '0;
            udp_rx_start      <= 1'b0;
            udp_rx_err        <= 1'b0;
            udp_rx_data_valid <= 1'b0;
            udp_rx_data_last  <= 1'b0;
            udp_rx_data       <= '0;
        end else begin
            udp_rx_start      <= start_nxt;
            udp_rx_err        <= err_nxt;
            udp_rx_data_valid <= dv_nxt;
            udp_rx_data_last  <= dlast_nxt;
            if (dv_nxt)
                udp_rx_data <= ip_rx_data;
            if (ip_rx_start) begin
                src_ip_q <= ip_rx_src_ip;
                hdr_cnt  <= '0;
            end else if (hdr_byte) begin
                hdr_cnt <= hdr_cnt + 3'd1;
                case (hdr_cnt)
                    3'd0:    src_port_q[15:8] <= ip_rx_data;
                    3'd1:    src_port_q[7:0]  <= ip_rx_data;
                    3'd2:    dst_port_q[15:8] <= ip_rx_data;
                    3'd3:    dst_port_q[7:0]  <= ip_rx_data;
                    3'd4:    len_q[15:8]      <= ip_rx_data;
                    3'd5:    len_q[7:0]       <= ip_rx_data;
                    default: ;
                endcase
            end
            if (start_nxt) begin
                hdr_out.src_ip      <= src_ip_q;
                hdr_out.src_port    <= src_port_q;
                hdr_out.dst_port    <= dst_port_q;
                hdr_out.data_length <= len_q - UDP_HDR_LEN;
                pay_cnt             <= len_q - UDP_HDR_LEN;
            end else if (pay_byte) begin
                pay_cnt <= pay_cnt - 16'd1;
            end
        end
    end

    assign udp_rx_src_ip      = hdr_out.src_ip;
    assign udp_rx_src_port    = hdr_out.src_port;
    assign udp_rx_dst_port    = hdr_out.dst_port;
    assign udp_rx_data_length = hdr_out.data_length;
    assign fsm_state          = state;

`ifdef UDP_RX_STATS_EN
    logic drop_evt;
    // Re-entering DISCARD through a fresh start counts as a new drop.
    assign drop_evt = err_nxt
                   || (state_nxt == UDP_RX_DISCARD && (state != UDP_RX_DISCARD || ip_rx_start));

    udp_rx_stats u_stats (
        .clk         (clk),
        .reset       (reset),
        .pkt_inc     (start_nxt),
        .drop_inc    (drop_evt),
        .rx_pkt_cnt  (rx_pkt_cnt),
        .rx_drop_cnt (rx_drop_cnt)
    );
`endif

endmodule

// File: tb/tb_udp_rx.sv
// Directed bench for udp_rx: an index-based packet model predicts header, beats and errors with cycle stamps.
module tb_udp_rx;
    import global_typs_pkg::*;

    localparam logic [15:0] PORT_FILTER = 16'h0050;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ip_rx_start = 1'b0;
    logic [7:0]    ip_rx_protocol = '0;
    logic [31:0]   ip_rx_src_ip = '0;
    logic          ip_rx_data_valid = 1'b0;
    logic [7:0]    ip_rx_data = '0;
    logic          ip_rx_data_last = 1'b0;
    logic          udp_rx_start;
    logic [31:0]   udp_rx_src_ip;
    logic [15:0]   udp_rx_src_port, udp_rx_dst_port, udp_rx_data_length;
    logic          udp_rx_data_valid;
    logic [7:0]    udp_rx_data;
    logic          udp_rx_data_last;
    logic          udp_rx_err;
    udp_rx_state_t fsm_state;
`ifdef UDP_RX_STATS_EN
    logic [15:0]   rx_pkt_cnt, rx_drop_cnt;
`endif

    udp_rx #(.PORT_FILTER(PORT_FILTER)) dut (
        .clk                (clk),
        .reset              (reset),
        .ip_rx_start        (ip_rx_start),
        .ip_rx_protocol     (ip_rx_protocol),
        .ip_rx_src_ip       (ip_rx_src_ip),
        .ip_rx_data_valid   (ip_rx_data_valid),
        .ip_rx_data         (ip_rx_data),
        .ip_rx_data_last    (ip_rx_data_last),
        .udp_rx_start       (udp_rx_start),
        .udp_rx_src_ip      (udp_rx_src_ip),
        .udp_rx_src_port    (udp_rx_src_port),
        .udp_rx_dst_port    (udp_rx_dst_port),
        .udp_rx_data_length (udp_rx_data_length),
        .udp_rx_data_valid  (udp_rx_data_valid),
        .udp_rx_data        (udp_rx_data),
        .udp_rx_data_last   (udp_rx_data_last),
        .udp_rx_err         (udp_rx_err),
        .fsm_state          (fsm_state)
`ifdef UDP_RX_STATS_EN
        ,
        .rx_pkt_cnt         (rx_pkt_cnt),
        .rx_drop_cnt        (rx_drop_cnt)
`endif
    );

    // ---- clock / reset ----
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ---- scoreboard ----
    int vectors = 0;
    int miscompares = 0;
    logic [111:0] exp_hdr_q[$];   // {cycle, src_ip, src_port, dst_port, data_length}
    logic [40:0]  exp_q[$];       // {cycle, last, data}
    logic [31:0]  exp_err_q[$];   // cycle
    logic [79:0]  held = '0;
    logic [79:0]  cur;
    logic [111:0] eh;
    logic [40:0]  eb;
    logic [31:0]  ee;
    int           starts_seen, beats_seen, errs_seen;
    logic [7:0]   last_data;
    logic [7:0]   pkt[0:31];
    bit           pending_abort = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cur = {udp_rx_src_ip, udp_rx_src_port, udp_rx_dst_port, udp_rx_data_length};
        if (reset) begin
            held = '0;
        end else begin
            vectors++;
            if (udp_rx_start) begin
                starts_seen++;
                if (exp_hdr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL hdr: unexpected udp_rx_start at cycle %0d", cyc);
                end else begin
                    eh = exp_hdr_q.pop_front();
                    if ({32'(cyc), cur} !== eh) begin
                        miscompares++;
                        $display("FAIL hdr: got %h expected %h", {32'(cyc), cur}, eh);
                    end
                end
                held = cur;
            end else if (cur !== held) begin
                miscompares++;
                $display("FAIL hdr_hold: got %h expected %h", cur, held);
            end
            if (udp_rx_data_valid) begin
                vectors++;
                beats_seen++;
                if (udp_rx_data_last) last_data = udp_rx_data;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat: unexpected data %h last %b at cycle %0d", udp_rx_data, udp_rx_data_last, cyc);
                end else begin
                    eb = exp_q.pop_front();
                    if ({32'(cyc), udp_rx_data_last, udp_rx_data} !== eb) begin
                        miscompares++;
                        $display("FAIL beat: got %h expected %h", {32'(cyc), udp_rx_data_last, udp_rx_data}, eb);
                    end
                end
            end
            if (udp_rx_err) begin
                vectors++;
                errs_seen++;
                if (exp_err_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL err: unexpected udp_rx_err at cycle %0d", cyc);
                end else begin
                    ee = exp_err_q.pop_front();
                    if (32'(cyc) !== ee) begin
                        miscompares++;
                        $display("FAIL err: got cycle %0d expected %0d", cyc, ee);
                    end
                end
            end
        end
    end

    // ---- driver tasks ----
    task automatic set_hdr(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len);
        pkt[0] = sp[15:8]; pkt[1] = sp[7:0];
        pkt[2] = dp[15:8]; pkt[3] = dp[7:0];
        pkt[4] = len[15:8]; pkt[5] = len[7:0];
        pkt[6] = 8'hA5;     pkt[7] = 8'h5A;
    endtask

    task automatic fill_payload(input int n);
        for (int i = 8; i < n; i++) pkt[i] = 8'(8'h10 + i);
    endtask

    task automatic clear_model();
        exp_hdr_q.delete();
        exp_q.delete();
        exp_err_q.delete();
    endtask

    // Model: byte index i of an n-byte IP payload decides every output from UDP header rules.
    task automatic send_pkt(input logic [7:0] proto, input logic [31:0] sip, input int n,
                            input int abort_at, input int reset_at);
        int s, c, len, pay;
        bit udp, acc;
        starts_seen = 0; beats_seen = 0; errs_seen = 0;
        udp = (proto == 8'd17);
        len = (n >= 6) ? int'({pkt[4], pkt[5]}) : 0;
        acc = (PORT_FILTER == 16'h0000) || ({pkt[2], pkt[3]} == PORT_FILTER);
        pay = len - 8;
        @(posedge clk); #1;
        s = cyc;
        ip_rx_start = 1'b1; ip_rx_protocol = proto; ip_rx_src_ip = sip;
        if (pending_abort) begin
            exp_err_q.push_back(32'(s + 1));
            pending_abort = 0;
        end
        @(posedge clk); #1;
        ip_rx_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (i == abort_at) begin
                pending_abort = 1;
                return;
            end
            if (i == reset_at) begin
                reset = 1'b1;
                #1;
                check("reset_outputs", {udp_rx_start, udp_rx_data_valid, udp_rx_data, udp_rx_data_last,
                       udp_rx_err, udp_rx_src_ip[15:0], udp_rx_src_port, udp_rx_data_length}, 64'd0);
                check("reset_hdr", {udp_rx_src_ip, udp_rx_dst_port}, 64'd0);
                check("reset_state", fsm_state, UDP_RX_IDLE);
                clear_model();
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            c = cyc;
            ip_rx_data_valid = 1'b1; ip_rx_data = pkt[i]; ip_rx_data_last = (i == n - 1);
            if (udp) begin
                if (i < 7 && i == n - 1) exp_err_q.push_back(32'(c + 1));
                if (i == 7) begin
                    if (len < 8) exp_err_q.push_back(32'(c + 1));
                    else if (acc) begin
                        exp_hdr_q.push_back({32'(c + 1), sip, pkt[0], pkt[1], pkt[2], pkt[3], 16'(pay)});
                        if (n == 8 && pay > 0) exp_err_q.push_back(32'(c + 1));
                    end
                end
                if (i >= 8 && len >= 8 && acc && (i - 8) < pay) begin
                    exp_q.push_back({32'(c + 1), ((i - 8) == pay - 1) || (i == n - 1), pkt[i]});
                    if (i == n - 1 && (i - 8) < pay - 1) exp_err_q.push_back(32'(c + 1));
                end
            end
            @(posedge clk); #1;
            ip_rx_data_valid = 1'b0; ip_rx_data_last = 1'b0;
        end
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
        check("hdr_q_empty", 64'(exp_hdr_q.size()), 64'd0);
        check("beat_q_empty", 64'(exp_q.size()), 64'd0);
        check("err_q_empty", 64'(exp_err_q.size()), 64'd0);
        check("idle_after_pkt", fsm_state, UDP_RX_IDLE);
    endtask

    // ---- directed sequence ----
    initial begin
        #2;
        check("reset_state_init", fsm_state, UDP_RX_IDLE);
        check("reset_out_init", {udp_rx_start, udp_rx_data_valid, udp_rx_data_last, udp_rx_err, udp_rx_data}, 64'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // filtered destination port
        set_hdr(16'h1234, 16'h0051, 16'd12); fill_payload(12);
        send_pkt(8'd17, 32'h0A000001, 12, -1, -1);
        drain();
        check("filter_starts", 64'(starts_seen), 64'd0);
        check("filter_beats", 64'(beats_seen), 64'd0);
        check("filter_errs", 64'(errs_seen), 64'd0);
`ifdef UDP_RX_STATS_EN
        check("filter_drop_cnt", rx_drop_cnt, 64'd1);
        check("filter_pkt_cnt", rx_pkt_cnt, 64'd0);
`endif

        // basic datagram DE AD BE EF
        set_hdr(16'h1234, 16'h0050, 16'd12);
        pkt[8] = 8'hDE; pkt[9] = 8'hAD; pkt[10] = 8'hBE; pkt[11] = 8'hEF;
        send_pkt(8'd17, 32'hC0A80001, 12, -1, -1);
        drain();
        check("basic_starts", 64'(starts_seen), 64'd1);
        check("basic_beats", 64'(beats_seen), 64'd4);
        check("basic_last_data", last_data, 64'hEF);
        check("basic_len", udp_rx_data_length, 64'd4);
        check("basic_ports", {udp_rx_src_port, udp_rx_dst_port}, 64'h1234_0050);
        check("basic_src_ip", udp_rx_src_ip, 64'hC0A80001);
        check("basic_errs", 64'(errs_seen), 64'd0);
`ifdef UDP_RX_STATS_EN
        check("basic_pkt_cnt", rx_pkt_cnt, 64'd1);
`endif

        // IP padding after a short UDP payload
        set_hdr(16'h2000, 16'h0050, 16'd10); fill_payload(14);
        send_pkt(8'd17, 32'h0A000002, 14, -1, -1);
        drain();
        check("pad_beats", 64'(beats_seen), 64'd2);
        check("pad_last_data", last_data, 64'h19);
        check("pad_errs", 64'(errs_seen), 64'd0);

        // IP datagram ends before UDP length is satisfied
        set_hdr(16'h3000, 16'h0050, 16'd20); fill_payload(13);
        send_pkt(8'd17, 32'h0A000003, 13, -1, -1);
        drain();
        check("trunc_beats", 64'(beats_seen), 64'd5);
        check("trunc_errs", 64'(errs_seen), 64'd1);
        check("trunc_len", udp_rx_data_length, 64'd12);

        // TCP datagram is ignored, then an empty UDP datagram
        set_hdr(16'h4000, 16'h0050, 16'd12); fill_payload(12);
        send_pkt(8'd6, 32'h0A000004, 12, -1, -1);
        drain();
        check("tcp_starts", 64'(starts_seen + beats_seen + errs_seen), 64'd0);
        set_hdr(16'h4001, 16'h0050, 16'd8);
        send_pkt(8'd17, 32'h0A000005, 8, -1, -1);
        drain();
        check("empty_starts", 64'(starts_seen), 64'd1);
        check("empty_beats", 64'(beats_seen), 64'd0);
        check("empty_len", udp_rx_data_length, 64'd0);

        // length below the header size
        set_hdr(16'h5000, 16'h0050, 16'd5); fill_payload(10);
        send_pkt(8'd17, 32'h0A000006, 10, -1, -1);
        drain();
        check("short_len_errs", 64'(errs_seen), 64'd1);
        check("short_len_starts", 64'(starts_seen), 64'd0);

        // IP ends inside the UDP header
        set_hdr(16'h6000, 16'h0050, 16'd12);
        send_pkt(8'd17, 32'h0A000007, 5, -1, -1);
        drain();
        check("hdr_cut_errs", 64'(errs_seen), 64'd1);

        // new datagram aborts one stuck in the header
        set_hdr(16'h7000, 16'h0050, 16'd12); fill_payload(12);
        send_pkt(8'd17, 32'h0A000008, 12, 4, -1);
        set_hdr(16'h1234, 16'h0050, 16'd12); fill_payload(12);
        send_pkt(8'd17, 32'h0A000009, 12, -1, -1);
        drain();
        check("abort_errs", 64'(errs_seen), 64'd1);
        check("abort_beats", 64'(beats_seen), 64'd4);

        // reset in the middle of the payload, then a clean datagram
        set_hdr(16'h8000, 16'h0050, 16'd16); fill_payload(16);
        send_pkt(8'd17, 32'h0A00000A, 16, -1, 10);
        set_hdr(16'h8001, 16'h0050, 16'd12); fill_payload(12);
        send_pkt(8'd17, 32'h0A00000B, 12, -1, -1);
        drain();
        check("post_reset_starts", 64'(starts_seen), 64'd1);
        check("post_reset_beats", 64'(beats_seen), 64'd4);
        check("post_reset_src_ip", udp_rx_src_ip, 64'h0A00000B);
`ifdef UDP_RX_STATS_EN
        check("post_reset_pkt_cnt", rx_pkt_cnt, 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/udp_rx.md
UDP_RX -- requirements
Module: udp_rx

Interface
REQ-001 SHALL have parameter PORT_FILTER, default 16'h0000, local destination port to accept; 0 accepts all ports.
REQ-002 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ip_rx_start  in  1  one-cycle pulse: new IP datagram, IP header fields valid.
REQ-005 SHALL have port ip_rx_protocol  in  8  IP protocol field, sampled on ip_rx_start.
REQ-006 SHALL have port ip_rx_src_ip  in  32  IP source address, sampled on ip_rx_start.
REQ-007 SHALL have ports ip_rx_data_valid  in  1, ip_rx_data  in  8 and ip_rx_data_last  in  1: the IP payload byte stream; last marks the final byte.
REQ-008 SHALL have port udp_rx_start  out  1  one-cycle pulse: UDP header outputs valid.
REQ-009 SHALL have ports udp_rx_src_ip  out  32, udp_rx_src_port  out  16, udp_rx_dst_port  out  16 and udp_rx_data_length  out  16 (payload bytes = UDP length - 8).
REQ-010 SHALL have ports udp_rx_data_valid  out  1, udp_rx_data  out  8 and udp_rx_data_last  out  1: the payload stream.
REQ-011 SHALL have port udp_rx_err  out  1  one-cycle error pulse.

Function
REQ-012 SHALL implement the FSM IDLE, HDR, PAYLOAD and DISCARD; the stream has no backpressure.
REQ-013 SHALL, in IDLE, on ip_rx_start with protocol 17, capture src_ip, clear the header byte counter and go to HDR; any other protocol SHALL go to DISCARD.
REQ-014 SHALL, in HDR, parse 8 valid bytes big-endian: bytes 0-1 src port, 2-3 dst port, 4-5 length, 6-7 checksum (checksum ignored).
REQ-015 SHALL, after byte 7: if length < 8, pulse udp_rx_err and go to DISCARD.
REQ-016 SHALL, after byte 7: if PORT_FILTER != 0 and dst port != PORT_FILTER, go to DISCARD with no error.
REQ-017 SHALL otherwise register the header outputs and pulse udp_rx_start in the cycle after byte 7, then go to PAYLOAD, or to DISCARD if length == 8.
REQ-018 SHALL hold the header outputs stable until the next udp_rx_start.
REQ-019 SHALL, in PAYLOAD, forward each valid byte with exactly 1 cycle latency and count down the payload counter.
REQ-020 SHALL assert udp_rx_data_last on the byte that exhausts the payload count; if ip_rx_data_last is not also set, it SHALL then go to DISCARD (IP padding dropped), otherwise to IDLE.
REQ-021 SHALL, on ip_rx_data_last before the count is exhausted, forward that byte with udp_rx_data_last=1, pulse udp_rx_err in the same cycle and go to IDLE.
REQ-022 SHALL, on ip_rx_data_last during HDR, pulse udp_rx_err, emit no udp_rx_start and go to IDLE.
REQ-023 SHALL, in DISCARD, drop bytes until ip_rx_data_last, then go to IDLE.
REQ-024 SHALL, on ip_rx_start outside IDLE, abort the current packet: pulse udp_rx_err, emit a udp_rx_data_last beat only if one is pending in the output register, and restart as from IDLE in the same cycle.

Reset
REQ-025 SHALL, while reset is asserted, immediately force FSM=IDLE and all outputs and counters to 0, including mid-packet; no partial packet resumes afterwards.

Configuration
REQ-026 SHALL, with UDP_RX_STATS_EN defined, add outputs rx_pkt_cnt (16) and rx_drop_cnt (16), both saturating and reset to 0.
REQ-027 SHALL increment rx_pkt_cnt on each udp_rx_start and rx_drop_cnt on each DISCARD entry or udp_rx_err.
REQ-028 SHALL, without UDP_RX_STATS_EN, have neither port nor the counters, with behaviour otherwise identical.

Structure
REQ-029 SHALL take UDP_PROTO=8'd17, UDP_HDR_LEN=8 and the udp_rx_hdr_t struct (src_ip, src_port, dst_port, data_length) from global_typs_pkg.
REQ-030 SHALL place the statistics counters in sub-module udp_rx_stats, instantiated only under UDP_RX_STATS_EN.

Verification
REQ-031 SHALL cover: protocol 17, ports 0x1234->0x0050, length 12, payload DE AD BE EF -> one start, 4 data beats one cycle delayed, last on EF, data_length 4.
REQ-032 SHALL cover: length 10 with 6 IP payload bytes after the header (4 padding) -> 2 data beats, last on byte 2, padding dropped, no err.
REQ-033 SHALL cover: length 20 and IP last after 5 payload bytes -> 5 beats, last and err on beat 5.
REQ-034 SHALL cover: PORT_FILTER=0x0050 with dst 0x0051 -> no start, no data, no err; rx_drop_cnt=1 when UDP_RX_STATS_EN.
REQ-035 SHALL cover: reset asserted on payload byte 2, then a clean packet -> outputs 0 asynchronously; second packet received intact.
REQ-036 SHALL cover: protocol 6 (TCP) packet -> no outputs; a following UDP packet with length 8 -> start pulse, zero data beats.
